// File: rtl/wb_arbiter.sv
// wb_arbiter -- two-master pipelined Wishbone arbiter in front of one slave.
//
// M0 is the MCU-side master (spi1_controller); M1 is a second bus master.
// Ownership is granted round-robin and held for a whole bus cycle. Accepted
// strobes are counted so that acks go back to the owner. The grant only
// changes after the owner ends its cycle, through one IDLE clock.
//
// Ports
//   wb_clock_i, wb_reset_ni         clock, asynchronous active-low reset
//   mN_addr_i/data_i/we_i           master N request (N = 0, 1)
//   mN_cycle_i/strobe_i             master N bus cycle and strobe
//   mN_data_o/stall_o/ack_o         master N read data, stall, ack
//   s_addr_o/data_o/we_o            request forwarded to the slave
//   s_cycle_o/strobe_o              slave cycle and strobe
//   s_data_i/stall_i/ack_i          slave response
//   grant_o                         one-hot owner {M1, M0}, 00 = idle
//   timeout_o                       one-clock pulse when the watchdog fires
//
// Build option: define WB_ARB_TIMEOUT_EN to enable the ack watchdog. When the
// watchdog fires, the arbiter acks the owner with all-ones data.
//
// state     | meaning
// ST_IDLE   | no owner, slave outputs 0, both masters stalled
// ST_GRANT0 | M0 owns the slave bus
// ST_GRANT1 | M1 owns the slave bus
module wb_arbiter #(
    parameter int WB_ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH     = 8,
    parameter int PEND_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_ni,
    input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0]    m0_data_i,
    output logic [DATA_WIDTH-1:0]    m0_data_o,
    input  logic                     m0_we_i,
    input  logic                     m0_cycle_i,
    input  logic                     m0_strobe_i,
    output logic                     m0_stall_o,
    output logic                     m0_ack_o,
    input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0]    m1_data_i,
    output logic [DATA_WIDTH-1:0]    m1_data_o,
    input  logic                     m1_we_i,
    input  logic                     m1_cycle_i,
    input  logic                     m1_strobe_i,
    output logic                     m1_stall_o,
    output logic                     m1_ack_o,
    output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0]    s_data_o,
    input  logic [DATA_WIDTH-1:0]    s_data_i,
    output logic                     s_we_o,
    output logic                     s_cycle_o,
    output logic                     s_strobe_o,
    input  logic                     s_stall_i,
    input  logic                     s_ack_i,
    output logic [1:0]               grant_o,
    output logic                     timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    state_t                state_q;
    state_t                state_d;
    logic                  last_q;      // previous owner: 0 = M0, 1 = M1
    logic [PEND_WIDTH-1:0] pend_q;
    logic                  own_cycle;
    logic                  pend_full;
    logic                  own_stall;
    logic                  ack_ok;
    logic                  tmo_hit;
    logic                  pend_inc;
    logic                  pend_dec;
    logic [DATA_WIDTH-1:0] rd_data;

    assign pend_full = (pend_q == PEND_MAX);
    assign own_stall = s_stall_i | pend_full;
    // An ack with nothing outstanding belongs to no one; drop it.
    assign ack_ok    = (state_q != ST_IDLE) & s_ack_i & (pend_q != '0);
    assign pend_inc  = s_strobe_o & ~own_stall;
    assign pend_dec  = ack_ok | tmo_hit;
    assign rd_data   = tmo_hit ? '1 : s_data_i;
    assign m0_data_o = rd_data;
    assign m1_data_o = rd_data;
    assign timeout_o = tmo_hit;

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cycle_i && m1_cycle_i) begin
                    state_d = last_q ? ST_GRANT0 : ST_GRANT1;
                end else if (m0_cycle_i) begin
                    state_d = ST_GRANT0;
                end else if (m1_cycle_i) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0: if (!m0_cycle_i) state_d = ST_IDLE;
            ST_GRANT1: if (!m1_cycle_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The strobe is withheld from the slave while the pending counter is
    // full. Otherwise the slave could accept a transfer that the owner still
    // sees as stalled.
    always_comb begin
        grant_o    = 2'b00;
        own_cycle  = 1'b0;
        s_addr_o   = '0;
        s_data_o   = '0;
        s_we_o     = 1'b0;
        s_cycle_o  = 1'b0;
        s_strobe_o = 1'b0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        case (state_q)
            ST_GRANT0: begin
                grant_o    = 2'b01;
                own_cycle  = m0_cycle_i;
                s_addr_o   = m0_addr_i;
                s_data_o   = m0_data_i;
                s_we_o     = m0_we_i;
                s_cycle_o  = m0_cycle_i;
                s_strobe_o = m0_strobe_i & ~pend_full;
                m0_stall_o = own_stall;
                m0_ack_o   = ack_ok | tmo_hit;
            end
            ST_GRANT1: begin
                grant_o    = 2'b10;
                own_cycle  = m1_cycle_i;
                s_addr_o   = m1_addr_i;
                s_data_o   = m1_data_i;
                s_we_o     = m1_we_i;
                s_cycle_o  = m1_cycle_i;
                s_strobe_o = m1_strobe_i & ~pend_full;
                m1_stall_o = own_stall;
                m1_ack_o   = ack_ok | tmo_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            last_q <= 1'b1;
        end else if (state_q == ST_GRANT0 && !m0_cycle_i) begin
            last_q <= 1'b0;
        end else if (state_q == ST_GRANT1 && !m1_cycle_i) begin
            last_q <= 1'b1;
        end
    end

    // When the owner drops its cycle (a normal end or an abort), the pending
    // count is cleared. Acks that arrive late then find nothing to route.
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            pend_q <= '0;
        end else if (!own_cycle) begin
            pend_q <= '0;
        end else if (pend_inc && !pend_dec) begin
            pend_q <= pend_q + PEND_WIDTH'(1);
        end else if (!pend_inc && pend_dec) begin
            pend_q <= pend_q - PEND_WIDTH'(1);
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;

    // The count runs on each clock that has strobes outstanding and no ack.
    // It fires on the TIMEOUT_CYCLES-th such clock in a row.
    assign wd_run  = (pend_q != '0) & ~s_ack_i;
    assign tmo_hit = wd_run & (wd_cnt == '0);

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            wd_cnt <= WD_LOAD;
        end else if (!wd_run || tmo_hit) begin
            wd_cnt <= WD_LOAD;
        end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int AW   = 20;
    localparam int DW   = 8;
    localparam int PW   = 3;
    localparam int TMO  = 16;
    localparam int PMAX = (1 << PW) - 1;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_wdat, m1_wdat, s_wdat;
    logic [DW-1:0] m0_rdat, m1_rdat, s_rdat;
    logic          m0_we, m0_cyc, m0_stb, m0_stall, m0_ack;
    logic          m1_we, m1_cyc, m1_stb, m1_stall, m1_ack;
    logic          s_we, s_cyc, s_stb, s_stall, s_ack;
    logic [1:0]    grant;
    logic          tmo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter #(
        .WB_ADDR_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .PEND_WIDTH    (PW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clock_i (clk),
        .wb_reset_ni(rst_n),
        .m0_addr_i  (m0_addr),
        .m0_data_i  (m0_wdat),
        .m0_data_o  (m0_rdat),
        .m0_we_i    (m0_we),
        .m0_cycle_i (m0_cyc),
        .m0_strobe_i(m0_stb),
        .m0_stall_o (m0_stall),
        .m0_ack_o   (m0_ack),
        .m1_addr_i  (m1_addr),
        .m1_data_i  (m1_wdat),
        .m1_data_o  (m1_rdat),
        .m1_we_i    (m1_we),
        .m1_cycle_i (m1_cyc),
        .m1_strobe_i(m1_stb),
        .m1_stall_o (m1_stall),
        .m1_ack_o   (m1_ack),
        .s_addr_o   (s_addr),
        .s_data_o   (s_wdat),
        .s_data_i   (s_rdat),
        .s_we_o     (s_we),
        .s_cycle_o  (s_cyc),
        .s_strobe_o (s_stb),
        .s_stall_i  (s_stall),
        .s_ack_i    (s_ack),
        .grant_o    (grant),
        .timeout_o  (tmo)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: owner index (-1 = none), last owner, outstanding
    // strobes, and clocks spent waiting on an ack with strobes outstanding.
    int owner, last_own, pend, wd;
    bit e_acc, e_dec, e_tmo;

    task automatic model_reset();
        owner = -1; last_own = 1; pend = 0; wd = 0;
    endtask

    task automatic check_outputs();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, erd;
        logic [1:0]    eg;
        bit ewe, ecyc, estb, full, st0, st1, ak0, ak1, route, ostall;
        ea = '0; ed = '0; eg = 2'b00; ewe = 0; ecyc = 0; estb = 0;
        st0 = 1; st1 = 1; ak0 = 0; ak1 = 0;
        full   = (pend == PMAX);
        ostall = s_stall || full;
        e_tmo  = TMO_EN && owner >= 0 && pend > 0 && !s_ack && (wd == TMO - 1);
        route  = owner >= 0 && ((s_ack && pend > 0) || e_tmo);
        if (owner == 0) begin
            ea = m0_addr; ed = m0_wdat; ewe = m0_we; ecyc = m0_cyc;
            estb = m0_stb && !full; eg = 2'b01; st0 = ostall; ak0 = route;
        end else if (owner == 1) begin
            ea = m1_addr; ed = m1_wdat; ewe = m1_we; ecyc = m1_cyc;
            estb = m1_stb && !full; eg = 2'b10; st1 = ostall; ak1 = route;
        end
        e_acc = estb && !ostall;
        e_dec = route;
        erd   = e_tmo ? {DW{1'b1}} : s_rdat;
        check("grant",    grant,    eg);
        check("s_addr",   s_addr,   ea);
        check("s_wdata",  s_wdat,   ed);
        check("s_we",     s_we,     ewe);
        check("s_cycle",  s_cyc,    ecyc);
        check("s_strobe", s_stb,    estb);
        check("m0_stall", m0_stall, st0);
        check("m1_stall", m1_stall, st1);
        check("m0_ack",   m0_ack,   ak0);
        check("m1_ack",   m1_ack,   ak1);
        check("m0_rdata", m0_rdat,  erd);
        check("m1_rdata", m1_rdat,  erd);
        check("timeout",  tmo,      e_tmo);
    endtask

    task automatic model_advance();
        if (owner < 0) begin
            if (m0_cyc && m1_cyc) owner = (last_own == 1) ? 0 : 1;
            else if (m0_cyc)      owner = 0;
            else if (m1_cyc)      owner = 1;
        end else if (!(owner == 0 ? m0_cyc : m1_cyc)) begin
            last_own = owner; owner = -1; pend = 0; wd = 0;
        end else begin
            if (pend > 0 && !s_ack && !e_tmo) wd++;
            else wd = 0;
            pend = pend + int'(e_acc) - int'(e_dec);
        end
    endtask

    task automatic settle();
        #2;
        check_outputs();
    endtask

    task automatic advance();
        model_advance();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic all_idle();
        m0_addr = '0; m0_wdat = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
        m1_addr = '0; m1_wdat = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
        s_rdat = '0; s_stall = 0; s_ack = 0;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("rst_grant", grant, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        m0_cyc  = m0_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
        m1_cyc  = m1_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
        m0_stb  = m0_cyc && ($urandom_range(1) == 1);
        m1_stb  = m1_cyc && ($urandom_range(1) == 1);
        m0_addr = AW'($urandom); m1_addr = AW'($urandom);
        m0_wdat = DW'($urandom); m1_wdat = DW'($urandom);
        m0_we   = ($urandom_range(1) == 1);
        m1_we   = ($urandom_range(1) == 1);
        s_stall = ($urandom_range(3) == 0);
        s_ack   = ($urandom_range(2) == 0);
        s_rdat  = DW'($urandom);
    endtask

    initial begin
        all_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        check("rst_m0_stall", m0_stall, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single M0 read, slave acks two clocks after the strobe is accepted
        m0_addr = 20'h08000; m0_cyc = 1; m0_stb = 1;
        step();
        settle(); check("a_grant", grant, 2'b01); check("a_addr", s_addr, 20'h08000);
        check("a_m1_stall", m1_stall, 1'b1); advance();
        m0_stb = 0;
        settle(); check("a_m1_stall", m1_stall, 1'b1); advance();
        s_ack = 1; s_rdat = 8'h5A;
        settle(); check("a_ack", m0_ack, 1'b1); check("a_data", m0_rdat, 8'h5A);
        check("a_m1_ack", m1_ack, 1'b0); advance();
        s_ack = 0; m0_cyc = 0;
        settle(); check("a_ack_once", m0_ack, 1'b0); advance();
        step();

        // Tie after reset: M0 first, one idle clock, then M1; tie again -> M1
        do_reset();
        all_idle(); m0_cyc = 1; m1_cyc = 1;
        step();
        settle(); check("b_grant_m0", grant, 2'b01); advance();
        m0_cyc = 0;
        step();
        m0_cyc = 1;
        settle(); check("b_idle_gap", grant, 2'b00); advance();
        settle(); check("b_grant_m1", grant, 2'b10); advance();
        m1_cyc = 0;
        step();
        settle(); check("b_idle_gap2", grant, 2'b00); advance();
        settle(); check("b_grant_m0b", grant, 2'b01); advance();
        m0_cyc = 0;
        step();
        step();

        // Pending saturation: 7 accepted, 8th stalled until one ack
        all_idle(); m0_cyc = 1; m0_stb = 1;
        step();
        for (int k = 1; k <= PMAX; k++) begin
            settle(); check("c_accept", m0_stall, 1'b0); advance();
        end
        settle(); check("c_stall8", m0_stall, 1'b1); check("c_strobe8", s_stb, 1'b0); advance();
        s_ack = 1;
        settle(); check("c_ack", m0_ack, 1'b1); check("c_stall_ack", m0_stall, 1'b1); advance();
        s_ack = 0;
        settle(); check("c_accept8", m0_stall, 1'b0); advance();
        m0_stb = 0;
        settle(); check("c_full_again", m0_stall, 1'b1); advance();
        m0_cyc = 0;
        step();
        step();

        // M1: strobe and ack in the same clock at pending 2 keeps it at 2
        all_idle(); m1_cyc = 1; m1_stb = 1;
        step();
        step();
        step();
        s_ack = 1;
        settle(); check("d_ack0", m1_ack, 1'b1); advance();
        m1_stb = 0;
        settle(); check("d_ack1", m1_ack, 1'b1); advance();
        settle(); check("d_ack2", m1_ack, 1'b1); advance();
        settle(); check("d_drop", m1_ack, 1'b0); advance();
        s_ack = 0; m1_cyc = 0;
        step();
        step();

        // Abort by M0 with three strobes outstanding; late ack is discarded
        all_idle(); m0_cyc = 1; m0_stb = 1;
        repeat (4) step();
        m0_cyc = 0; m0_stb = 0;
        settle(); check("e_cyc_drop", s_cyc, 1'b0); advance();
        s_ack = 1;
        settle(); check("e_m0_ack", m0_ack, 1'b0); check("e_m1_ack", m1_ack, 1'b0);
        check("e_grant", grant, 2'b00); advance();
        s_ack = 0;
        step();

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: slave never acks a single strobe
        all_idle(); m0_cyc = 1; m0_stb = 1;
        step();
        step();
        m0_stb = 0;
        for (int i = 1; i < TMO; i++) begin
            settle(); check("f_wait", m0_ack, 1'b0); advance();
        end
        settle(); check("f_ack", m0_ack, 1'b1); check("f_data", m0_rdat, 8'hFF);
        check("f_pulse", tmo, 1'b1); advance();
        settle(); check("f_pulse_end", tmo, 1'b0); check("f_no_ack", m0_ack, 1'b0); advance();
        m0_cyc = 0;
        step();
`endif

        // Randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            rand_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
